// File: rtl/clk_div_pkg.sv
// ============================================================================
//  clk_div_pkg : shared defaults and divisor clamp for the clock divider
//  Rev 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

   localparam int c_CNT_W    = 16;
   localparam int c_DEF_DIV  = 1000;
   localparam int c_DEF_HIGH = 500;

   // A divided clock needs at least one high and one low cycle.
   function automatic logic [31:0] eff_div(input logic [31:0] d);
      return (d < 32'd2) ? 32'd2 : d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
//  clk_div_chan : one divider channel with active/pending settings
//  Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = c_CNT_W,
   parameter int DEF_DIV  = c_DEF_DIV,
   parameter int DEF_HIGH = c_DEF_HIGH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic             i_resync,
   input  logic [CNT_W-1:0] i_div,
   input  logic [CNT_W-1:0] i_high,
   output logic             o_clk,
   output logic             o_tick,
   output logic             o_busy
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_a;
   logic [CNT_W-1:0] r_high_a;
   logic [CNT_W-1:0] r_div_p;
   logic [CNT_W-1:0] r_high_p;
   logic             r_pend;
   logic             r_clk;
   logic             r_tick;

   logic [CNT_W-1:0] w_last;
   logic             w_tc;

   assign w_last = CNT_W'(eff_div(32'(r_div_a)) - 32'd1);
   assign w_tc   = (r_cnt == w_last) | ~i_en | i_resync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_div_a  <= CNT_W'(DEF_DIV);
         r_high_a <= CNT_W'(DEF_HIGH);
         r_div_p  <= CNT_W'(DEF_DIV);
         r_high_p <= CNT_W'(DEF_HIGH);
         r_pend   <= 1'b0;
         r_clk    <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         if (w_tc) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         // Settings pending before this cycle apply at the boundary; a load in
         // the same cycle only refills the pending slot.
         if (w_tc && r_pend) begin
            r_div_a  <= r_div_p;
            r_high_a <= r_high_p;
         end

         if (i_load) begin
            r_div_p  <= i_div;
            r_high_p <= i_high;
            r_pend   <= 1'b1;
         end else if (w_tc) begin
            r_pend   <= 1'b0;
         end

         r_clk  <= i_en & (r_cnt < r_high_a);
         r_tick <= i_en & (r_cnt == '0);
      end
   end

   assign o_clk  = r_clk;
   assign o_tick = r_tick;
   assign o_busy = r_pend;

endmodule

`default_nettype wire

// File: rtl/clk_divider_multi.sv
// ============================================================================
//  clk_divider_multi : NUM_CH independent programmable clock dividers
//  Rev 1.0
// ============================================================================
`default_nettype none

module clk_divider_multi
   import clk_div_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = c_CNT_W,
   parameter int DEF_DIV  = c_DEF_DIV,
   parameter int DEF_HIGH = c_DEF_HIGH
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*CNT_W-1:0] div,
   input  logic [NUM_CH*CNT_W-1:0] high,
   input  logic [NUM_CH-1:0]       load,
   input  logic                    resync,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       busy
);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_chan #(
         .CNT_W    (CNT_W),
         .DEF_DIV  (DEF_DIV),
         .DEF_HIGH (DEF_HIGH)
      ) u_chan (
         .clk      (clk_in),
         .rst      (rst),
         .i_en     (en[gi]),
         .i_load   (load[gi]),
         .i_resync (resync),
         .i_div    (div[gi*CNT_W +: CNT_W]),
         .i_high   (high[gi*CNT_W +: CNT_W]),
         .o_clk    (clk_out[gi]),
         .o_tick   (tick[gi]),
         .o_busy   (busy[gi])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_clk_divider_multi.sv
// ============================================================================
//  tb_clk_divider_multi : directed scenarios plus random traffic vs a model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_divider_multi;

   localparam int NCH = 4;
   localparam int CW  = 16;

   typedef struct {
      int unsigned d;
      int unsigned h;
   } setting_t;

   logic              clk_in = 1'b0;
   logic              rst    = 1'b1;
   logic [NCH-1:0]    en     = '1;
   logic [NCH*CW-1:0] div    = '0;
   logic [NCH*CW-1:0] high   = '0;
   logic [NCH-1:0]    load   = '0;
   logic              resync = 1'b0;
   logic [NCH-1:0]    clk_out;
   logic [NCH-1:0]    tick;
   logic [NCH-1:0]    busy;

   clk_divider_multi #(
      .NUM_CH   (NCH),
      .CNT_W    (CW),
      .DEF_DIV  (1000),
      .DEF_HIGH (500)
   ) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .div     (div),
      .high    (high),
      .load    (load),
      .resync  (resync),
      .clk_out (clk_out),
      .tick    (tick),
      .busy    (busy)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: phase within the current period, active setting, and a queue
   // holding at most one not-yet-applied setting.
   int unsigned m_phase [NCH];
   int unsigned m_div   [NCH];
   int unsigned m_high  [NCH];
   setting_t    m_pend  [NCH][$];
   logic [NCH-1:0] e_clk, e_tick, e_busy;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_phase[k] = 0;
         m_div[k]   = 1000;
         m_high[k]  = 500;
         m_pend[k].delete();
      end
      e_clk  = '0;
      e_tick = '0;
      e_busy = '0;
   endtask

   task automatic model_step();
      for (int k = 0; k < NCH; k++) begin
         int unsigned period;
         bit          bnd;
         setting_t    s;
         period    = (m_div[k] < 2) ? 2 : m_div[k];
         bnd       = !en[k] || resync || (m_phase[k] == period - 1);
         e_clk[k]  = en[k] && (m_phase[k] < m_high[k]);
         e_tick[k] = en[k] && (m_phase[k] == 0);
         m_phase[k] = bnd ? 0 : m_phase[k] + 1;
         if (bnd && m_pend[k].size() > 0) begin
            s = m_pend[k].pop_front();
            m_div[k]  = s.d;
            m_high[k] = s.h;
         end
         if (load[k]) begin
            s.d = div[k*CW +: CW];
            s.h = high[k*CW +: CW];
            if (m_pend[k].size() > 0) m_pend[k][0] = s;
            else                      m_pend[k].push_back(s);
         end
         e_busy[k] = (m_pend[k].size() > 0);
      end
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge,
   // then the one-cycle strobes are withdrawn.
   task automatic cycle();
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      check_eq("clk_out", 32'(clk_out), 32'(e_clk));
      check_eq("tick",    32'(tick),    32'(e_tick));
      check_eq("busy",    32'(busy),    32'(e_busy));
      load   = '0;
      resync = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_count(input int n, input int ch, output int highs, output int ticks);
      highs = 0;
      ticks = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         highs += int'(clk_out[ch]);
         ticks += int'(tick[ch]);
      end
   endtask

   task automatic set_ch(input int ch, input int unsigned d, input int unsigned h);
      div[ch*CW +: CW]  = CW'(d);
      high[ch*CW +: CW] = CW'(h);
      load[ch]          = 1'b1;
   endtask

   function automatic int unsigned period_of(input int ch);
      return (m_div[ch] < 2) ? 2 : m_div[ch];
   endfunction

   initial begin
      int hi, tk, guard;
      model_reset();
      #1;
      check_eq("rst_clk_out", 32'(clk_out), 32'd0);
      check_eq("rst_tick",    32'(tick),    32'd0);
      check_eq("rst_busy",    32'(busy),    32'd0);
      repeat (5) @(negedge clk_in);
      rst = 1'b0;

      // Defaults: 1000-cycle period, 500 high.
      run_count(2000, 0, hi, tk);
      check_eq("def_highs", 32'(hi), 32'd1000);
      check_eq("def_ticks", 32'(tk), 32'd2);

      // Mid-period reload of channel 1.
      run(200);
      set_ch(1, 10, 3);
      cycle();
      check_eq("reload_busy", 32'(busy[1]), 32'd1);
      run(1000);
      run_count(20, 1, hi, tk);
      check_eq("reload_highs", 32'(hi), 32'd6);
      check_eq("reload_ticks", 32'(tk), 32'd2);

      // Clamps and constant-level outputs.
      set_ch(0, 0, 1);
      set_ch(1, 1, 1);
      set_ch(2, 8, 12);
      set_ch(3, 5, 0);
      run(1010);
      run_count(40, 0, hi, tk);
      check_eq("div0_highs", 32'(hi), 32'd20);
      run_count(40, 1, hi, tk);
      check_eq("div1_ticks", 32'(tk), 32'd20);
      run_count(40, 2, hi, tk);
      check_eq("const_hi_highs", 32'(hi), 32'd40);
      check_eq("const_hi_ticks", 32'(tk), 32'd5);
      run_count(40, 3, hi, tk);
      check_eq("const_lo_highs", 32'(hi), 32'd0);
      check_eq("const_lo_ticks", 32'(tk), 32'd8);

      // Resync of two channels with coprime-ish periods.
      set_ch(0, 4, 2);
      set_ch(1, 6, 3);
      run(20 + int'($urandom_range(0, 7)));
      resync = 1'b1;
      cycle();
      cycle();
      check_eq("resync_tick", 32'(tick[1:0]), 32'd3);
      run(12);
      check_eq("resync_tick12", 32'(tick[1:0]), 32'd3);

      // Load coincident with the terminal count of channel 2 (period 8).
      guard = 0;
      while (m_phase[2] != period_of(2) - 1 && guard < 100) begin
         cycle();
         guard++;
      end
      check_eq("tc_wait_bound", 32'(guard < 100), 32'd1);
      set_ch(2, 6, 2);
      cycle();
      check_eq("tc_load_busy", 32'(busy[2]), 32'd1);
      run(20);

      // Drop enable in the high part of channel 0 (period 10, high 6).
      set_ch(0, 10, 6);
      run(30);
      guard = 0;
      while (m_phase[0] != 2 && guard < 100) begin
         cycle();
         guard++;
      end
      check_eq("en_wait_bound", 32'(guard < 100), 32'd1);
      en[0] = 1'b0;
      cycle();
      cycle();
      check_eq("en_drop_clk", 32'(clk_out[0]), 32'd0);
      en[0] = 1'b1;
      run(25);

      // Asynchronous reset with a pending setting outstanding.
      set_ch(3, 700, 300);
      cycle();
      #2 rst = 1'b1;
      #1;
      check_eq("arst_clk_out", 32'(clk_out), 32'd0);
      check_eq("arst_tick",    32'(tick),    32'd0);
      check_eq("arst_busy",    32'(busy),    32'd0);
      model_reset();
      repeat (5) @(negedge clk_in);
      rst = 1'b0;
      run_count(1005, 3, hi, tk);
      check_eq("post_rst_highs", 32'(hi), 32'd505);
      check_eq("post_rst_ticks", 32'(tk), 32'd2);

      // Random traffic with small divisors.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NCH; k++) begin
            if ($urandom_range(0, 39) == 0) en[k] = ~en[k];
            if ($urandom_range(0, 7) == 0)
               set_ch(k, $urandom_range(0, 12), $urandom_range(0, 14));
         end
         if ($urandom_range(0, 59) == 0) resync = 1'b1;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
